// File: rtl/avs_obi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// avs_obi_bridge_pkg
// Shared types and constants for the Avalon-MM slave to Ibex-style OBI
// master bridge.
//   MAX_DEPTH   : largest supported in-flight tracker depth
//   ERR_RDATA   : read data returned to Avalon when the OBI response errors
//   trk_entry_t : one in-order tracker entry (is this response a read?)
//   byte_rev / bit_rev4 : helpers used when AVS_OBI_ENDIAN_SWAP_EN is set
// ---------------------------------------------------------------------------
package avs_obi_bridge_pkg;

  localparam int unsigned MAX_DEPTH = 4;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic is_read;
  } trk_entry_t;

  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] bit_rev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

// File: rtl/avs_obi_rsp_fifo.sv
// ---------------------------------------------------------------------------
// avs_obi_rsp_fifo
// In-order tracker of accepted OBI transactions. One entry per request,
// popped by each response, so responses map back to their requests in
// issue order.
// Parameters:
//   Depth : number of entries (1..MAX_DEPTH)
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push, push_data : enqueue an entry
//   pop, pop_data   : dequeue the oldest entry (pop_data is the head)
//   full, empty     : occupancy flags
// The caller never pushes while full nor pops while empty.
// ---------------------------------------------------------------------------
module avs_obi_rsp_fifo
  import avs_obi_bridge_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  trk_entry_t push_data,
  input  logic       pop,
  output trk_entry_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam logic [1:0] LAST_IDX  = 2'(Depth - 1);
  localparam logic [2:0] DEPTH_CNT = 3'(Depth);

  trk_entry_t mem [MAX_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  // Pointers wrap at Depth rather than at the storage size so that a
  // non-power-of-two depth behaves as a true ring.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset: stale contents are never read because
  // the pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == 3'd0);

endmodule

// File: rtl/avs_obi_bridge.sv
// ---------------------------------------------------------------------------
// avs_obi_bridge
// Avalon-MM slave (word addressed, pipelined reads) to Ibex-style OBI
// master bridge. Commands pass straight through to the OBI request channel;
// an in-order tracker records which accepted transactions are reads so the
// OBI responses can be turned into Avalon readdatavalid pulses.
// Parameters:
//   MaxOutstanding : max in-flight OBI transactions (1..4)
//   AddrBase       : byte offset added to the translated address
// Ports:
//   clk_i, rst_i                          : clock, async active-high reset
//   avs_address/read/write/byteenable/writedata : Avalon command
//   avs_waitrequest/readdata/readdatavalid      : Avalon response
//   req_o, gnt_i, we_o, be_o, addr_o, wdata_o   : OBI request channel
//   rvalid_i, rdata_i, err_i                    : OBI response channel
//   proto_err_o : sticky, response arrived with nothing outstanding
//   err_cnt_o   : saturating count of error responses
// Configuration macro:
//   AVS_OBI_ENDIAN_SWAP_EN : byte-reverse write/read data, bit-reverse be_o
// ---------------------------------------------------------------------------
module avs_obi_bridge
  import avs_obi_bridge_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] AddrBase       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [3:0]  avs_byteenable,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        proto_err_o,
  output logic [7:0]  err_cnt_o
);

  logic        cmd;
  logic        accept;
  logic        pop;
  logic        full;
  logic        empty;
  trk_entry_t  push_entry;
  trk_entry_t  pop_entry;
  logic [31:0] rsp_data;

  logic        vld_p1;
  logic [31:0] rdata_p1;
  logic        proto_err_q;
  logic [7:0]  err_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign cmd             = avs_read | avs_write;
  // Gating with rst_i keeps the request quiet for the whole reset window,
  // not only after the first clock edge.
  assign req_o           = cmd & ~full & ~rst_i;
  assign accept          = req_o & gnt_i;
  assign avs_waitrequest = ~accept;

  assign we_o   = avs_write;
  assign addr_o = {avs_address, 2'b00} + AddrBase;

`ifdef AVS_OBI_ENDIAN_SWAP_EN
  assign wdata_o  = byte_rev(avs_writedata);
  assign be_o     = bit_rev4(avs_byteenable);
  assign rsp_data = byte_rev(rdata_i);
`else
  assign wdata_o  = avs_writedata;
  assign be_o     = avs_byteenable;
  assign rsp_data = rdata_i;
`endif

  assign push_entry.is_read = avs_read;
  // A response with nothing outstanding (e.g. left over from before a reset)
  // must not disturb the tracker.
  assign pop = rvalid_i & ~empty;

  avs_obi_rsp_fifo #(
    .Depth(MaxOutstanding)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (accept),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (pop_entry),
    .full     (full),
    .empty    (empty)
  );

  // ---- response stage p1: register read data one cycle after rvalid_i ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      rdata_p1    <= '0;
      proto_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      vld_p1 <= pop & pop_entry.is_read;
      if (pop & pop_entry.is_read) begin
        rdata_p1 <= err_i ? ERR_RDATA : rsp_data;
      end
      if (rvalid_i & empty) proto_err_q <= 1'b1;
      if (rvalid_i & err_i) err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign avs_readdatavalid = vld_p1;
  assign avs_readdata      = rdata_p1;
  assign proto_err_o       = proto_err_q;
  assign err_cnt_o         = err_cnt_q;

endmodule

// File: tb/tb_avs_obi_bridge.sv
module tb_avs_obi_bridge;
  import avs_obi_bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        req_o;
  logic        gnt_i;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;
  logic        proto_err_o;
  logic [7:0]  err_cnt_o;

  int checks = 0;
  int errors = 0;

  avs_obi_bridge dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_byteenable   (avs_byteenable),
    .avs_writedata    (avs_writedata),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .req_o            (req_o),
    .gnt_i            (gnt_i),
    .we_o             (we_o),
    .be_o             (be_o),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .rvalid_i         (rvalid_i),
    .rdata_i          (rdata_i),
    .err_i            (err_i),
    .proto_err_o      (proto_err_o),
    .err_cnt_o        (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected-value helpers for the endian-swap build option.
  function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef AVS_OBI_ENDIAN_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] b);
`ifdef AVS_OBI_ENDIAN_SWAP_EN
    return {b[0], b[1], b[2], b[3]};
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; avs_address = '0; avs_read = 1'b1; avs_write = 1'b0;
    avs_byteenable = 4'hF; avs_writedata = '0; gnt_i = 1'b1;
    rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;

    // Reset state, with a read command present
    #2;
    chk("rst_req", req_o, 1'b0);
    chk("rst_wait", avs_waitrequest, 1'b1);
    chk("rst_rdv", avs_readdatavalid, 1'b0);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_proto", proto_err_o, 1'b0);
    chk("rst_errcnt", err_cnt_o, 8'h00);
    step(); step();
    rst_i = 1'b0; avs_read = 1'b0; gnt_i = 1'b0;
    step();

    // Read, grant withheld 3 cycles
    avs_address = 30'h10; avs_read = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", addr_o, 32'h40);
      chk("t1_req", req_o, 1'b1);
      chk("t1_wait_hi", avs_waitrequest, 1'b1);
      step();
    end
    gnt_i = 1'b1; #1;
    chk("t1_wait_lo", avs_waitrequest, 1'b0);
    chk("t1_we", we_o, 1'b0);
    step();
    avs_read = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678; #1;
    chk("t1_rdv_early", avs_readdatavalid, 1'b0);
    step();
    rvalid_i = 1'b0; #1;
    chk("t1_rdv", avs_readdatavalid, 1'b1);
    chk("t1_rdata", avs_readdata, exp_data(32'h1234_5678));
    step(); #1;
    chk("t1_rdv_end", avs_readdatavalid, 1'b0);

    // Write, then its response
    avs_write = 1'b1; avs_address = 30'h3; avs_byteenable = 4'b0011;
    avs_writedata = 32'hAABB_CCDD; gnt_i = 1'b1; #1;
    chk("t2_addr", addr_o, 32'h0000_000C);
    chk("t2_we", we_o, 1'b1);
    chk("t2_be", be_o, exp_be(4'b0011));
    chk("t2_wdata", wdata_o, exp_data(32'hAABB_CCDD));
    chk("t2_wait", avs_waitrequest, 1'b0);
    step();
    avs_write = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; #1;
    step();
    rvalid_i = 1'b0; #1;
    chk("t2_no_rdv", avs_readdatavalid, 1'b0);
    chk("t2_proto", proto_err_o, 1'b0);

    // Back-to-back reads, depth 2: count back at 0 so two accept, third stalls
    avs_read = 1'b1; gnt_i = 1'b1; avs_address = 30'h20; avs_byteenable = 4'hF; #1;
    chk("t3_r1_wait", avs_waitrequest, 1'b0);
    step(); #1;
    chk("t3_r2_wait", avs_waitrequest, 1'b0);
    step(); #1;
    chk("t3_r3_req", req_o, 1'b0);
    chk("t3_r3_wait", avs_waitrequest, 1'b1);
    step();
    rvalid_i = 1'b1; rdata_i = 32'h1111_1111; #1;
    chk("t3_full_req", req_o, 1'b0);
    step();
    rdata_i = 32'h2222_2222; #1;
    chk("t3_d1_rdv", avs_readdatavalid, 1'b1);
    chk("t3_d1", avs_readdata, exp_data(32'h1111_1111));
    chk("t3_acc_pop_wait", avs_waitrequest, 1'b0);
    step();
    rvalid_i = 1'b0; #1;
    chk("t3_d2", avs_readdata, exp_data(32'h2222_2222));
    chk("t3_r4_wait", avs_waitrequest, 1'b0);
    step(); #1;
    chk("t3_r5_stall", avs_waitrequest, 1'b1);
    chk("t3_rdv_idle", avs_readdatavalid, 1'b0);
    avs_read = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h3333_3333;
    step();
    rdata_i = 32'h4444_4444; #1;
    chk("t3_d3", avs_readdata, exp_data(32'h3333_3333));
    step();
    rvalid_i = 1'b0; #1;
    chk("t3_d4", avs_readdata, exp_data(32'h4444_4444));
    chk("t3_d4_rdv", avs_readdatavalid, 1'b1);
    step(); #1;

    // Error read, then error-count saturation
    avs_read = 1'b1; gnt_i = 1'b1;
    step();
    avs_read = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'h5555_5555;
    step();
    rvalid_i = 1'b0; err_i = 1'b0; #1;
    chk("t4_err_rdata", avs_readdata, 32'hDEAD_BEEF);
    chk("t4_err_rdv", avs_readdatavalid, 1'b1);
    chk("t4_errcnt1", err_cnt_o, 8'h01);
    avs_write = 1'b1; gnt_i = 1'b1;
    step();
    rvalid_i = 1'b1; err_i = 1'b1;
    for (int i = 0; i < 299; i++) begin
      step();
      if (i == 99) begin
        chk("t4_errcnt101", err_cnt_o, 8'd101);
        chk("t4_steady_wait", avs_waitrequest, 1'b0);
      end
    end
    avs_write = 1'b0; gnt_i = 1'b0;
    step();
    rvalid_i = 1'b0; err_i = 1'b0; #1;
    chk("t4_errcnt_sat", err_cnt_o, 8'hFF);
    chk("t4_proto", proto_err_o, 1'b0);
    chk("t4_wr_no_rdv", avs_readdatavalid, 1'b0);

    // Reset with 2 outstanding, stale response afterwards
    avs_read = 1'b1; gnt_i = 1'b1;
    step(); step();
    rst_i = 1'b1; #1;
    chk("t5_rst_req", req_o, 1'b0);
    chk("t5_rst_wait", avs_waitrequest, 1'b1);
    chk("t5_rst_errcnt", err_cnt_o, 8'h00);
    avs_read = 1'b0; gnt_i = 1'b0;
    step();
    rst_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h6666_6666;
    step();
    rvalid_i = 1'b0; #1;
    chk("t5_proto", proto_err_o, 1'b1);
    chk("t5_no_rdv", avs_readdatavalid, 1'b0);
    step(); #1;
    chk("t5_proto_sticky", proto_err_o, 1'b1);

    // Byte lane ordering on a fresh read
    avs_read = 1'b1; gnt_i = 1'b1; avs_byteenable = 4'b0001; #1;
    chk("t6_wait", avs_waitrequest, 1'b0);
    chk("t6_be", be_o, exp_be(4'b0001));
    step();
    avs_read = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1122_3344;
    step();
    rvalid_i = 1'b0; #1;
    chk("t6_rdv", avs_readdatavalid, 1'b1);
    chk("t6_rdata", avs_readdata, exp_data(32'h1122_3344));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
